// File: rtl/conv_window_mul.sv
// conv_window_mul: front end of the convolution datapath.
// Buffers one FILTER_SIZE x FILTER_SIZE filter and one IFMAP_SIZE x IFMAP_SIZE
// ifmap, then streams one row of elementwise window*weight products per output
// pixel in raster order (stride 1, no padding).
// Build option: define CONV_SIGNED_MUL_EN to treat weights and pixels as two's
// complement; otherwise they are zero-extended unsigned values.
module conv_window_mul #(
  parameter int IP_DATA_WIDTH = 8,
  parameter int IFMAP_SIZE    = 5,
  parameter int FILTER_SIZE   = 3,
  parameter int OFMAP_SIZE    = IFMAP_SIZE - FILTER_SIZE + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          w_valid,
  input  logic [IP_DATA_WIDTH-1:0]      w_data,
  output logic                          w_ready,
  input  logic                          if_valid,
  input  logic [IP_DATA_WIDTH-1:0]      if_data,
  output logic                          if_ready,
  output logic                          prod_valid,
  input  logic                          prod_ready,
  output logic [FILTER_SIZE*FILTER_SIZE-1:0][2*IP_DATA_WIDTH-1:0] prod_row,
  output logic [$clog2(OFMAP_SIZE*OFMAP_SIZE)-1:0] prod_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int W    = IP_DATA_WIDTH;
  localparam int PW   = 2 * IP_DATA_WIDTH;
  localparam int KK   = FILTER_SIZE * FILTER_SIZE;
  localparam int NPIX = IFMAP_SIZE * IFMAP_SIZE;
  localparam int NOUT = OFMAP_SIZE * OFMAP_SIZE;
  localparam int WCW  = (KK > 1) ? $clog2(KK) : 1;
  localparam int PCW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int IDXW = $clog2(NOUT);
  localparam int RCW  = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_LOAD_IF = 3'd2;
  localparam logic [2:0] S_EMIT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]      state_reg;
  logic [WCW-1:0]  w_cnt_reg;
  logic [PCW-1:0]  if_cnt_reg;
  logic [RCW-1:0]  r_reg;
  logic [RCW-1:0]  c_reg;
  logic [IDXW-1:0] idx_reg;
  logic            prod_valid_reg;
  logic [KK-1:0][PW-1:0] prod_row_reg;

  // Operand storage; deliberately not reset so a job can reuse nothing stale
  // only by reloading, never by clearing.
  logic [W-1:0] w_buf  [KK];
  logic [W-1:0] if_buf [NPIX];

  logic w_take;
  logic if_take;
  logic w_last;
  logic if_last;
  logic emit_go;
  logic row_hs;
  logic row_last;
  logic c_wrap;

  // Window position of the row about to be registered.
  logic [RCW-1:0] tgt_r_next;
  logic [RCW-1:0] tgt_c_next;

  logic [PCW-1:0] addr_next [KK];
  logic [W-1:0]   pix_next  [KK];
  logic [PW-1:0]  prod_next [KK];

  assign w_take   = (state_reg == S_LOAD_W) && w_valid;
  assign if_take  = (state_reg == S_LOAD_IF) && if_valid;
  assign w_last   = (w_cnt_reg == WCW'(KK - 1));
  assign if_last  = (if_cnt_reg == PCW'(NPIX - 1));
  assign emit_go  = if_take && if_last;
  assign row_hs   = (state_reg == S_EMIT) && prod_valid_reg && prod_ready;
  assign row_last = (idx_reg == IDXW'(NOUT - 1));
  assign c_wrap   = (c_reg == RCW'(OFMAP_SIZE - 1));

  // Row 0 when entering EMIT, otherwise the raster successor of (r, c).
  always_comb begin
    tgt_r_next = '0;
    tgt_c_next = '0;
    if (!emit_go) begin
      if (c_wrap) begin
        tgt_c_next = '0;
        tgt_r_next = r_reg + RCW'(1);
      end else begin
        tgt_c_next = c_reg + RCW'(1);
        tgt_r_next = r_reg;
      end
    end
  end

  // One multiplier per filter tap. The pixel read bypasses the buffer when
  // the last pixel is arriving on the same edge that registers row 0.
  generate
    for (genvar gi = 0; gi < KK; gi++) begin : g_tap
      assign addr_next[gi] = (PCW'(tgt_r_next) + PCW'(gi / FILTER_SIZE)) * PCW'(IFMAP_SIZE)
                           + PCW'(tgt_c_next) + PCW'(gi % FILTER_SIZE);
      assign pix_next[gi]  = (if_take && (if_cnt_reg == addr_next[gi])) ? if_data
                                                                        : if_buf[addr_next[gi]];
`ifdef CONV_SIGNED_MUL_EN
      assign prod_next[gi] = $signed({{W{w_buf[gi][W-1]}}, w_buf[gi]})
                           * $signed({{W{pix_next[gi][W-1]}}, pix_next[gi]});
`else
      assign prod_next[gi] = {{W{1'b0}}, w_buf[gi]} * {{W{1'b0}}, pix_next[gi]};
`endif
    end
  endgenerate

  // Capture accepted weight and pixel beats at their running addresses.
  always_ff @(posedge clk) begin
    if (w_take) begin
      w_buf[w_cnt_reg] <= w_data;
    end
    if (if_take) begin
      if_buf[if_cnt_reg] <= if_data;
    end
  end

  // Job sequencer, beat counters, window position and the output row register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      w_cnt_reg      <= '0;
      if_cnt_reg     <= '0;
      r_reg          <= '0;
      c_reg          <= '0;
      idx_reg        <= '0;
      prod_valid_reg <= 1'b0;
      prod_row_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg  <= S_LOAD_W;
            w_cnt_reg  <= '0;
            if_cnt_reg <= '0;
          end
        end
        S_LOAD_W: begin
          if (w_valid) begin
            if (w_last) begin
              state_reg <= S_LOAD_IF;
              w_cnt_reg <= '0;
            end else begin
              w_cnt_reg <= w_cnt_reg + WCW'(1);
            end
          end
        end
        S_LOAD_IF: begin
          if (if_valid) begin
            if (if_last) begin
              state_reg      <= S_EMIT;
              if_cnt_reg     <= '0;
              prod_valid_reg <= 1'b1;
              idx_reg        <= '0;
              r_reg          <= '0;
              c_reg          <= '0;
              for (int k = 0; k < KK; k++) begin
                prod_row_reg[k] <= prod_next[k];
              end
            end else begin
              if_cnt_reg <= if_cnt_reg + PCW'(1);
            end
          end
        end
        S_EMIT: begin
          if (row_hs) begin
            if (row_last) begin
              prod_valid_reg <= 1'b0;
              state_reg      <= S_DONE;
            end else begin
              idx_reg <= idx_reg + IDXW'(1);
              r_reg   <= tgt_r_next;
              c_reg   <= tgt_c_next;
              for (int k = 0; k < KK; k++) begin
                prod_row_reg[k] <= prod_next[k];
              end
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign w_ready    = (state_reg == S_LOAD_W);
  assign if_ready   = (state_reg == S_LOAD_IF);
  assign prod_valid = prod_valid_reg;
  assign prod_row   = prod_row_reg;
  assign prod_idx   = idx_reg;
  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);

endmodule
